// File: rtl/flag_unit_pkg.sv
// Shared constants and types for the flag register and branch condition logic.
package flag_unit_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FR_FLAG_W = 4;
  localparam int unsigned COND_W    = 4;

  localparam int unsigned N_FLAG = 3;
  localparam int unsigned Z_FLAG = 2;
  localparam int unsigned C_FLAG = 1;
  localparam int unsigned V_FLAG = 0;

  // Flag register layout, MSB first: {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } fr_t;

  typedef enum logic [COND_W-1:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_CS = 4'd3,
    COND_CC = 4'd4,
    COND_MI = 4'd5,
    COND_PL = 4'd6,
    COND_VS = 4'd7,
    COND_VC = 4'd8,
    COND_HI = 4'd9,
    COND_LS = 4'd10,
    COND_GE = 4'd11,
    COND_LT = 4'd12,
    COND_GT = 4'd13,
    COND_LE = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator; shared with the branch unit.
module cond_eval
  import flag_unit_pkg::*;
(
  input  logic [COND_W-1:0]    cond,
  input  logic [FR_FLAG_W-1:0] flags,
  output logic                 cond_true
);

  fr_t f;
  assign f = fr_t'(flags);

  // C is the ALU's "no borrow" bit, so HI/LS are unsigned higher / lower-or-same
  always_comb begin
    cond_true = 1'b0;
    unique case (cond_e'(cond))
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = f.z;
      COND_NE: cond_true = ~f.z;
      COND_CS: cond_true = f.c;
      COND_CC: cond_true = ~f.c;
      COND_MI: cond_true = f.n;
      COND_PL: cond_true = ~f.n;
      COND_VS: cond_true = f.v;
      COND_VC: cond_true = ~f.v;
      COND_HI: cond_true = f.c & ~f.z;
      COND_LS: cond_true = ~f.c | f.z;
      COND_GE: cond_true = f.n ~^ f.v;
      COND_LT: cond_true = f.n ^ f.v;
      COND_GT: cond_true = ~f.z & (f.n ~^ f.v);
      COND_LE: cond_true = f.z | (f.n ^ f.v);
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural flag register with condition evaluation and a small
// LIFO of saved flag values for interrupt/call save and restore.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FR_FLAG_W-1:0] alu_flags,
  input  logic                 flag_we,
  input  logic                 fr_load,
  input  logic [DATA_W-1:0]    fr_din,
  input  logic                 push,
  input  logic                 pop,
  input  logic [COND_W-1:0]    cond,
  output logic                 cond_true,
  output logic [FR_FLAG_W-1:0] flags,
  output logic [DATA_W-1:0]    fr_dout,
  output logic                 stk_empty,
  output logic                 stk_full,
  output logic                 stk_err
);

  localparam int unsigned SP_W  = $clog2(STK_DEPTH) + 1;
  localparam int unsigned IDX_W = SP_W - 1;

  logic [FR_FLAG_W-1:0] fr, fr_nxt;
  logic [SP_W-1:0]      sp, sp_nxt;
  logic                 err_nxt;
  logic [FR_FLAG_W-1:0] stk_mem [STK_DEPTH];
  logic                 push_ok, pop_ok;
  logic [IDX_W-1:0]     wr_idx, top_idx;
  logic                 unused_din;

  assign unused_din = ^fr_din[DATA_W-1:FR_FLAG_W];

  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SP_W'(STK_DEPTH));
  assign push_ok   = push & ~pop & ~stk_full;
  assign pop_ok    = pop & ~push & ~stk_empty;
  assign wr_idx    = IDX_W'(sp);
  assign top_idx   = IDX_W'(sp - SP_W'(1));

  assign flags   = fr;
  assign fr_dout = {{(DATA_W - FR_FLAG_W){1'b0}}, fr};

  // A legal pop owns FR; otherwise load beats ALU capture
  always_comb begin
    fr_nxt  = fr;
    sp_nxt  = sp;
    err_nxt = (push | pop) & ~push_ok & ~pop_ok;
    if (pop_ok) begin
      fr_nxt = stk_mem[top_idx];
      sp_nxt = sp - SP_W'(1);
    end else begin
      if (fr_load) begin
        fr_nxt = fr_din[FR_FLAG_W-1:0];
      end else if (flag_we) begin
        fr_nxt = alu_flags;
      end
      if (push_ok) begin
        sp_nxt = sp + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr      <= '0;
      sp      <= '0;
      stk_err <= 1'b0;
    end else begin
      fr      <= fr_nxt;
      sp      <= sp_nxt;
      stk_err <= err_nxt;
    end
  end

  // Save slots hold the pre-edge FR; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stk_mem[wr_idx] <= fr;
    end
  end

  cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (fr),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_flag_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alu_flags = '0;
  logic        flag_we = 1'b0;
  logic        fr_load = 1'b0;
  logic [15:0] fr_din = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [3:0]  cond = '0;
  logic        cond_true;
  logic [3:0]  flags;
  logic [15:0] fr_dout;
  logic        stk_empty;
  logic        stk_full;
  logic        stk_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_fr = 0;
  int m_stk[$];
  int m_err = 0;

  flag_unit #(.STK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_flags (alu_flags),
    .flag_we   (flag_we),
    .fr_load   (fr_load),
    .fr_din    (fr_din),
    .push      (push),
    .pop       (pop),
    .cond      (cond),
    .cond_true (cond_true),
    .flags     (flags),
    .fr_dout   (fr_dout),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Branch semantics from the flag meanings: N,Z,C(no borrow),V
  function automatic bit ref_cond(input int c, input int f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    bit lt = (n != v);
    case (c)
      0:  return 1;
      1:  return z;
      2:  return !z;
      3:  return cy;
      4:  return !cy;
      5:  return n;
      6:  return !n;
      7:  return v;
      8:  return !v;
      9:  return cy && !z;
      10: return !cy || z;
      11: return !lt;
      12: return lt;
      13: return !z && !lt;
      14: return z || lt;
      default: return 0;
    endcase
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".flags"}, 16'(flags), 16'(m_fr));
    chk({tag, ".dout"}, fr_dout, 16'(m_fr));
    chk({tag, ".empty"}, 16'(stk_empty), 16'(m_stk.size() == 0));
    chk({tag, ".full"}, 16'(stk_full), 16'(m_stk.size() == DEPTH));
    chk({tag, ".err"}, 16'(stk_err), 16'(m_err));
  endtask

  // Drive one cycle of inputs, check cond_true pre-edge, advance model, check post-edge
  task automatic cycle(input bit i_push, input bit i_pop, input bit i_we, input int i_alu,
                       input bit i_ld, input int i_din, input int i_cond, input string tag);
    int sz;
    push = i_push; pop = i_pop; flag_we = i_we; alu_flags = 4'(i_alu);
    fr_load = i_ld; fr_din = 16'(i_din); cond = 4'(i_cond);
    #1;
    chk({tag, ".cond"}, 16'(cond_true), 16'(ref_cond(i_cond, m_fr)));
    @(posedge clk);
    sz = m_stk.size();
    m_err = (i_push && i_pop) || (i_push && !i_pop && sz == DEPTH) || (i_pop && !i_push && sz == 0);
    if (i_pop && !i_push && sz > 0) begin
      m_fr = m_stk.pop_back();
    end else begin
      if (i_push && !i_pop && sz < DEPTH) m_stk.push_back(m_fr);
      if (i_ld) m_fr = i_din & 15;
      else if (i_we) m_fr = i_alu;
    end
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic model_reset();
    m_fr = 0;
    m_stk.delete();
    m_err = 0;
  endtask

  initial begin
    #12;
    chk("rst.flags", 16'(flags), 16'h0);
    chk("rst.dout", fr_dout, 16'h0);
    chk("rst.empty", 16'(stk_empty), 16'h1);
    chk("rst.full", 16'(stk_full), 16'h0);
    chk("rst.err", 16'(stk_err), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU capture then signed compare
    cycle(0, 0, 1, 4'b1001, 0, 0, 0, "we");
    chk("we.flags_const", 16'(flags), 16'h0009);
    chk("we.dout_const", fr_dout, 16'h0009);
    cond = 4'd12; #1;
    chk("we.lt", 16'(cond_true), 16'h0);
    cond = 4'd11; #1;
    chk("we.ge", 16'(cond_true), 16'h1);

    // Full condition table over every FR value; upper data bits ignored
    for (int k = 0; k < 16; k++) begin
      cycle(0, 0, 0, 0, 1, 16'hFFF0 | k, 0, "sweep_ld");
      for (int c = 0; c < 16; c++) cycle(0, 0, 0, 0, 0, 0, c, "sweep");
    end

    // Load wins over ALU capture
    cycle(0, 0, 1, 4'b0010, 1, 16'h0004, 0, "ld_vs_we");
    chk("ld_vs_we.const", 16'(flags), 16'h0004);

    // Stack round trip with overflow and underflow
    for (int v = 1; v <= 4; v++) begin
      cycle(0, 0, 0, 0, 1, v, 0, "stk_ld");
      cycle(1, 0, 0, 0, 0, 0, 0, "stk_push");
    end
    chk("stk.full_const", 16'(stk_full), 16'h1);
    cycle(1, 0, 0, 0, 0, 0, 0, "stk_ovf");
    chk("stk_ovf.err_const", 16'(stk_err), 16'h1);
    idle("stk_ovf_clr");
    chk("stk_ovf.err_clear", 16'(stk_err), 16'h0);
    for (int v = 4; v >= 1; v--) begin
      cycle(0, 1, 0, 0, 0, 0, 0, "stk_pop");
      chk("stk_pop.const", 16'(flags), 16'(v));
    end
    chk("stk.empty_const", 16'(stk_empty), 16'h1);
    cycle(0, 1, 0, 0, 0, 0, 0, "stk_unf");
    chk("stk_unf.err_const", 16'(stk_err), 16'h1);
    chk("stk_unf.held", 16'(flags), 16'h1);

    // Push keeps pre-edge FR; pop discards a same-cycle ALU write
    cycle(0, 0, 0, 0, 1, 5, 0, "pw_ld");
    cycle(1, 0, 1, 4'hA, 0, 0, 0, "pw_push");
    chk("pw_push.const", 16'(flags), 16'h000A);
    cycle(0, 1, 1, 4'hF, 0, 0, 0, "pw_pop");
    chk("pw_pop.const", 16'(flags), 16'h0005);

    // Push and pop together, then asynchronous reset between edges
    cycle(1, 0, 0, 0, 0, 0, 0, "pp_fill");
    cycle(1, 0, 0, 0, 0, 0, 0, "pp_fill");
    cycle(1, 1, 1, 4'h3, 0, 0, 0, "pp_both");
    chk("pp_both.err_const", 16'(stk_err), 16'h1);
    idle("pp_after");
    cycle(0, 1, 0, 0, 0, 0, 0, "pp_pop");
    chk("pp_pop.depth", 16'(stk_empty), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.flags", 16'(flags), 16'h0);
    chk("arst.empty", 16'(stk_empty), 16'h1);
    chk("arst.full", 16'(stk_full), 16'h0);
    chk("arst.dout", fr_dout, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4), 1'($urandom),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 15)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Flag register and condition evaluator placed directly downstream of the ALU. Captures the ALU's N/Z/C/V outputs under control of the decoder and holds them as the architectural flag register (FR). Evaluates 4-bit branch condition codes against the held flags. Provides a small LIFO of saved FR values so the interrupt/call sequencer can save and restore flags.

## Interface
- `STK_DEPTH`, default 4: number of FR save slots (power of two, ≥2).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_flags`  in  `FR_FLAG_W` (4)  ALU flag outputs, bit order {N,Z,C,V} = {3,2,1,0}.
- `flag_we`  in  1  capture `alu_flags` into FR.
- `fr_load`  in  1  load FR from `fr_din[3:0]` (MOV-to-FR).
- `fr_din`  in  `DATA_W` (16)  data bus value; bits 15:4 are ignored.
- `push`  in  1  save the current FR to the stack.
- `pop`  in  1  restore FR from the top of the stack.
- `cond`  in  `COND_W` (4)  condition code to evaluate.
- `cond_true`  out  1  combinational result of `cond` against the registered FR.
- `flags`  out  4  registered FR.
- `fr_dout`  out  16  `{12'b0, flags}`, for reading FR onto the data bus.
- `stk_empty`  out  1  no saved entries.
- `stk_full`  out  1  `STK_DEPTH` entries saved.
- `stk_err`  out  1  registered one-cycle pulse on an illegal stack operation.

## Operation
- Reset, asynchronous while `rst_n`=0:
  - FR = 4'b0000, stack pointer = 0, `stk_err` = 0.
  - Outputs: `flags`=0, `fr_dout`=0, `stk_empty`=1, `stk_full`=0.
  - Stack storage contents are don't-care.
- FR next-value priority, highest first:
  1. Legal `pop`: FR ← stack top.
  2. `fr_load`: FR ← `fr_din[3:0]`.
  3. `flag_we`: FR ← `alu_flags`.
  4. Otherwise hold.
- Legal push (`push`=1, `pop`=0, not full): slot[sp] ← current FR (the pre-edge value), sp ← sp+1. A same-cycle `flag_we` or `fr_load` still updates FR.
- Legal pop (`pop`=1, `push`=0, not empty): sp ← sp−1, FR ← slot[sp−1]. Same-cycle `flag_we` and `fr_load` are discarded.
- Illegal stack operations leave sp and the stack unchanged and pulse `stk_err`:
  - push when full;
  - pop when empty;
  - push and pop together.
- FR priority 2–4 still applies in those illegal cycles.
- sp is `$clog2(STK_DEPTH)+1` bits wide. It never wraps; it saturates via the error rule above.
- Condition codes (`COND_*`):
  - 0 AL = 1; 1 EQ = Z; 2 NE = !Z
  - 3 CS = C; 4 CC = !C; 5 MI = N; 6 PL = !N
  - 7 VS = V; 8 VC = !V
  - 9 HI = C & !Z; 10 LS = !C | Z
  - 11 GE = N~^V; 12 LT = N^V
  - 13 GT = !Z & (N~^V); 14 LE = Z | (N^V)
  - 15 NV = 0
- HI/LS treat C as "no borrow" exactly as the ALU produces it: C is bit 16 of the 17-bit result.

## Timing
- FR update latency is 1 cycle: a write in cycle t is visible on `flags` and `cond_true` in cycle t+1.
- There is no bypass from `alu_flags` to `cond_true`. The decoder must not branch on flags in the same cycle they are written.
- `cond_true` is purely combinational from `cond` and the registered FR, with zero latency.
- `stk_empty` and `stk_full` are decoded from the registered sp. They are valid in the cycle after a push or pop.
- `stk_err` is asserted in the cycle after the offending edge and lasts exactly one cycle.
- `rst_n` asserted mid-operation clears everything immediately, without waiting for a clock edge. The first update after deassertion occurs at the first rising edge with `rst_n`=1.

## Structure
- Constants in shared `def.v`:
  - `FR_FLAG_W`, `N_FLAG`=3, `Z_FLAG`=2, `C_FLAG`=1, `V_FLAG`=0;
  - `COND_W`=4 and `COND_AL` … `COND_NV`;
  - `DATA_W` is already defined there.
- Sub-module `cond_eval`: purely combinational (`cond`, `flags`) → `cond_true`. It is reused by the branch unit.
- FR register, stack array, sp and error logic live in `flag_unit` itself.

## Test plan
- Reset, then `flag_we`=1 with `alu_flags`=4'b1001 → next cycle `flags`=4'b1001, `fr_dout`=16'h0009; `cond`=12 (LT) gives 0, `cond`=11 (GE) gives 1.
- Sweep all 16 `cond` values over all 16 FR values (loaded via `fr_load` with `fr_din`=16'hFFF0|k) → `cond_true` matches the table; `flags`=k, confirming bits 15:4 are ignored.
- Same cycle `fr_load` (`fr_din`=16'h0004) and `flag_we` (`alu_flags`=4'b0010) → `flags`=4'b0100.
- Stack round trip:
  - Push FR=4'h1, 4'h2, 4'h3, 4'h4 → `stk_full`=1.
  - 5th push → `stk_err` pulse, sp unchanged.
  - Four pops → FR = 4'h4, 4'h3, 4'h2, 4'h1, then `stk_empty`=1.
  - Extra pop → `stk_err` pulse, FR held.
- Push with `flag_we` (FR=4'h5, `alu_flags`=4'hA) → stack top 4'h5, FR=4'hA. Then pop with `flag_we` (`alu_flags`=4'hF) → FR=4'h5.
- Push+pop together with the stack holding 2 entries → `stk_err`=1 for one cycle, sp stays 2. Then assert `rst_n`=0 between clock edges → `flags`=0 and `stk_empty`=1 immediately.
